// File: rtl/victim_evict_buffer_pkg.sv
// Shared types and line-address constants for the victim eviction buffer.
// Imported by victim_evict_buffer and veb_tag_match.
package victim_cache_def;

    localparam int VEB_ADDR_W   = 32;
    localparam int VEB_LINE_W   = 128;
    localparam int VEB_OFFS_W   = 4;
    localparam int VEB_LINE_LSB = VEB_OFFS_W;
    localparam int VEB_LINE_MSB = VEB_ADDR_W - 1;
    localparam int VEB_LINE_AW  = VEB_LINE_MSB - VEB_LINE_LSB + 1;

    typedef struct packed {
        logic                  valid;
        logic [VEB_ADDR_W-1:0] addr;
        logic [VEB_LINE_W-1:0] data;
        logic                  dirty;
    } veb_entry_t;

endpackage

// File: rtl/victim_evict_buffer_tag_match.sv
// veb_tag_match: line-address compare of one address against every valid entry.
// Produces a one-hot match vector (coalescing keeps matches unique) and a hit flag.
module veb_tag_match
    import victim_cache_def::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = VEB_ADDR_W,
    parameter int OFFS_W = VEB_LINE_LSB
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  veb_entry_t        entries_i [DEPTH],
    output logic [DEPTH-1:0]  match_o,
    output logic              hit_o
);

    logic w_unused_bits;

    // Compare line addresses only; offset bits, data and dirty take no part.
    always_comb begin
        match_o       = {DEPTH{1'b0}};
        w_unused_bits = ^addr_i[OFFS_W-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = entries_i[i].valid &&
                         (entries_i[i].addr[ADDR_W-1:OFFS_W] == addr_i[ADDR_W-1:OFFS_W]);
            w_unused_bits = w_unused_bits ^ (^{entries_i[i].data, entries_i[i].dirty,
                                               entries_i[i].addr[OFFS_W-1:0]});
        end
    end

    assign hit_o = |match_o;

endmodule

// File: rtl/victim_evict_buffer.sv
// victim_evict_buffer: FIFO of evicted L1 lines awaiting the victim cache, with coalescing.
// Define VICTIM_EVICT_FWD_EN to enable the same-cycle lookup port; otherwise lookup outputs are 0.
module victim_evict_buffer
    import victim_cache_def::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = VEB_ADDR_W,
    parameter int LINE_W = VEB_LINE_W,
    parameter int OFFS_W = VEB_OFFS_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       evict_valid_i,
    input  logic [ADDR_W-1:0]          evict_addr_i,
    input  logic [LINE_W-1:0]          evict_data_i,
    input  logic                       evict_dirty_i,
    output logic                       evict_ready_o,
    output logic                       vc_valid_o,
    output logic [ADDR_W-1:0]          vc_addr_o,
    output logic [LINE_W-1:0]          vc_data_o,
    output logic                       vc_dirty_o,
    input  logic                       vc_ready_i,
    input  logic                       lookup_valid_i,
    input  logic [ADDR_W-1:0]          lookup_addr_i,
    output logic                       lookup_hit_o,
    output logic [LINE_W-1:0]          lookup_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [31:0]                no_push_o,
    output logic [31:0]                no_coal_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    veb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_no_push;
    logic [31:0]      r_no_coal;

    logic [DEPTH-1:0] w_coal_match;
    logic             w_coal_hit;
    logic             w_pop;
    logic             w_push;
    logic             w_push_coal;
    logic             w_push_new;

    veb_tag_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) u_coal_match (
        .addr_i    (evict_addr_i),
        .entries_i (r_mem),
        .match_o   (w_coal_match),
        .hit_o     (w_coal_hit)
    );

    // Ready uses the unmasked match so it never depends on vc_ready_i; a head match
    // that pops this cycle turns into a new push into the slot the pop frees.
    assign vc_valid_o    = (r_count != {CNT_W{1'b0}});
    assign w_pop         = vc_valid_o && vc_ready_i;
    assign evict_ready_o = (r_count < CNT_W'(DEPTH)) || w_coal_hit;
    assign w_push        = evict_valid_i && evict_ready_o;
    assign w_push_coal   = w_push && w_coal_hit && !(w_pop && w_coal_match[r_head]);
    assign w_push_new    = w_push && !w_push_coal;

    assign vc_addr_o  = r_mem[r_head].addr;
    assign vc_data_o  = r_mem[r_head].data;
    assign vc_dirty_o = r_mem[r_head].dirty;
    assign count_o    = r_count;
    assign no_push_o  = r_no_push;
    assign no_coal_o  = r_no_coal;

    // Entry storage, pointers, occupancy and statistics; a push at the tail overrides a pop clearing the same slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head    <= {PTR_W{1'b0}};
            r_tail    <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_no_push <= 32'd0;
            r_no_coal <= 32'd0;
        end else begin
            if (w_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            if (w_push_coal) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_coal_match[i]) begin
                        r_mem[i].data  <= evict_data_i;
                        r_mem[i].dirty <= r_mem[i].dirty | evict_dirty_i;
                    end
                end
                r_no_coal <= r_no_coal + 32'd1;
            end else if (w_push_new) begin
                r_mem[r_tail] <= '{valid: 1'b1, addr: evict_addr_i,
                                   data: evict_data_i, dirty: evict_dirty_i};
                r_tail        <= r_tail + PTR_W'(1);
                r_no_push     <= r_no_push + 32'd1;
            end
            case ({w_push_new, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef VICTIM_EVICT_FWD_EN
    logic [DEPTH-1:0]  w_lk_match;
    logic              w_lk_hit;
    logic [LINE_W-1:0] w_lk_data;

    veb_tag_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) u_lookup_match (
        .addr_i    (lookup_addr_i),
        .entries_i (r_mem),
        .match_o   (w_lk_match),
        .hit_o     (w_lk_hit)
    );

    // One-hot select of the matching entry's data.
    always_comb begin
        w_lk_data = {LINE_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_data = w_lk_data | (r_mem[i].data & {LINE_W{w_lk_match[i]}});
        end
    end

    assign lookup_hit_o  = lookup_valid_i && w_lk_hit;
    assign lookup_data_o = lookup_hit_o ? w_lk_data : {LINE_W{1'b0}};
`else
    logic w_lookup_unused;

    assign w_lookup_unused = lookup_valid_i ^ (^lookup_addr_i);
    assign lookup_hit_o    = 1'b0;
    assign lookup_data_o   = {LINE_W{1'b0}};
`endif

endmodule
